// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative 32-bit multiply/divide unit with architectural HI/LO registers
module muldiv_unit #(
  parameter int data_width = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [data_width-1:0] operand1,
  input  logic [data_width-1:0] operand2,
  input  logic [1:0]            opSel,
  input  logic                  start,
  input  logic                  hi_we,
  input  logic                  lo_we,
  input  logic [data_width-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic [data_width-1:0] hi,
  output logic [data_width-1:0] lo
);

  localparam int dw = data_width;
  localparam int cw = $clog2(dw);
  localparam logic [cw-1:0] last_cnt = cw'(dw - 1);

  typedef enum logic [1:0] {
    s_idle   = 2'd0,
    s_run    = 2'd1,
    s_finish = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [cw-1:0]   cnt;
  logic            is_div;     // latched opSel[1]
  logic            neg_res;    // product / quotient must be negated
  logic            neg_rem;    // remainder takes the dividend's sign
  logic            div_zero;   // divisor was zero at start
  logic [dw-1:0]   raw_a;      // operand1 as issued, returned in HI on divide by zero
  logic [dw-1:0]   mag_a;      // multiplicand / dividend magnitude
  logic [dw-1:0]   mag_b;      // multiplier / divisor magnitude
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide: low half holds dividend bits shifting out and quotient bits shifting in.
  logic [2*dw-1:0] acc;
  logic [dw:0]     rem;        // partial remainder for restoring division

  logic [dw-1:0]   hi_q, lo_q;
  logic            done_q;

  logic            accept;
  logic            a_neg, b_neg;
  logic [dw-1:0]   a_mag_in, b_mag_in;

  logic [dw:0]     mul_sum;
  logic [2*dw-1:0] mul_next;
  logic [dw:0]     div_shift;
  logic [dw:0]     div_diff;
  logic            div_ok;
  logic [dw:0]     rem_next;
  logic [dw-1:0]   quot_next;

  logic [2*dw-1:0] prod_fix;
  logic [dw-1:0]   quot_fix;
  logic [dw-1:0]   rem_fix;
  logic [dw-1:0]   res_hi, res_lo;

  assign accept = (state_q == s_idle) && start;

  // Operand sign handling: opSel[0]=0 selects the signed flavours.
  always_comb begin
    a_neg    = ~opSel[0] & operand1[dw-1];
    b_neg    = ~opSel[0] & operand2[dw-1];
    a_mag_in = a_neg ? (~operand1 + 1'b1) : operand1;
    b_mag_in = b_neg ? (~operand2 + 1'b1) : operand2;
  end

  // One radix-2 iteration of shift-add multiply and of restoring divide.
  always_comb begin
    mul_sum   = {1'b0, acc[2*dw-1:dw]} + (acc[0] ? {1'b0, mag_a} : {(dw+1){1'b0}});
    mul_next  = {mul_sum, acc[dw-1:1]};
    div_shift = {rem[dw-1:0], acc[dw-1]};
    div_diff  = div_shift - {1'b0, mag_b};
    div_ok    = ~div_diff[dw];
    rem_next  = div_ok ? div_diff : div_shift;
    quot_next = {acc[dw-2:0], div_ok};
  end

  // Sign fix-up and final HI/LO selection, including the divide-by-zero override.
  always_comb begin
    prod_fix = neg_res ? (~acc + 1'b1) : acc;
    quot_fix = neg_res ? (~acc[dw-1:0] + 1'b1) : acc[dw-1:0];
    rem_fix  = neg_rem ? (~rem[dw-1:0] + 1'b1) : rem[dw-1:0];
    if (!is_div) begin
      res_hi = prod_fix[2*dw-1:dw];
      res_lo = prod_fix[dw-1:0];
    end else if (div_zero) begin
      res_hi = raw_a;
      res_lo = {dw{1'b1}};
    end else begin
      res_hi = rem_fix;
      res_lo = quot_fix;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= s_idle;
    else     state_q <= state_d;
  end

  // Next-state logic: IDLE -> RUN on start, 32 RUN edges, one FINISH edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      s_idle:   if (start) state_d = s_run;
      s_run:    if (cnt == last_cnt) state_d = s_finish;
      s_finish: state_d = s_idle;
      default:  state_d = s_idle;
    endcase
  end

  // Operand latch at start and one iteration per RUN edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      raw_a    <= '0;
      mag_a    <= '0;
      mag_b    <= '0;
      acc      <= '0;
      rem      <= '0;
    end else if (accept) begin
      cnt      <= '0;
      is_div   <= opSel[1];
      neg_res  <= a_neg ^ b_neg;
      neg_rem  <= a_neg;
      div_zero <= (operand2 == '0);
      raw_a    <= operand1;
      mag_a    <= a_mag_in;
      mag_b    <= b_mag_in;
      acc      <= {{dw{1'b0}}, (opSel[1] ? a_mag_in : b_mag_in)};
      rem      <= '0;
    end else if (state_q == s_run) begin
      cnt <= cnt + 1'b1;
      if (is_div) begin
        acc <= {acc[2*dw-1:dw], quot_next};
        rem <= rem_next;
      end else begin
        acc <= mul_next;
      end
    end
  end

  // HI/LO: result on the FINISH edge, MTHI/MTLO only in IDLE when no start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state_q == s_finish) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end else if ((state_q == s_idle) && !start) begin
      if (hi_we) hi_q <= wdata;
      if (lo_we) lo_q <= wdata;
    end
  end

  // Completion pulse in the first cycle the new HI/LO are visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) done_q <= 1'b0;
    else     done_q <= (state_q == s_finish);
  end

  assign busy = (state_q != s_idle);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic [31:0] operand1, operand2, wdata;
  logic [1:0]  opsel;
  logic        start, hi_we, lo_we;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total;
  int bad;

  muldiv_unit #(.data_width(32)) dut (
    .clk(clk), .rst(rst), .operand1(operand1), .operand2(operand2),
    .opSel(opsel), .start(start), .hi_we(hi_we), .lo_we(lo_we),
    .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; returns {hi, lo}.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    if (op == 2'b00) begin
      p = sa * sb;
      return p;
    end
    if (op == 2'b01) begin
      p = ua * ub;
      return p;
    end
    if (b == 32'b0) return {a, 32'hFFFFFFFF};
    if (op == 2'b10) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = ua / ub;
      r = ua % ub;
    end
    return {r[31:0], q[31:0]};
  endfunction

  // Issue at the current cycle (cycle 0); return in the cycle done is seen.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cnt);
    opsel    = op;
    operand1 = a;
    operand2 = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    lat      = 1;
    busy_cnt = 0;
    while (!done && lat < 80) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat, bcnt, dones, cyc;
    logic [63:0] exp;
    logic [31:0] old_hi;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    total = 0;
    bad   = 0;
    rst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    opsel = 2'b00; operand1 = '0; operand2 = '0; wdata = '0;

    vecs[0] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{2'b00, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{2'b11, 32'd100,      32'h00000000, 32'd100,      32'hFFFFFFFF};
    vecs[4] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5] = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[6] = '{2'b10, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[7] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[8] = '{2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};

    #2;
    check("reset_busy", {63'b0, busy}, 64'd0);
    check("reset_done", {63'b0, done}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Table vectors, each issued back-to-back in the done cycle of the previous one.
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd34);
      check($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), 64'd33);
      check($sformatf("vec%0d_busy_at_done", i), {63'b0, busy}, 64'd0);
      check($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].hi));
      check($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].lo));
    end
    tick();
    check("done_one_cycle", {63'b0, done}, 64'd0);

    // Start and operand changes while busy must not disturb the running operation.
    exp = model(2'b01, 32'd12345, 32'd6789);
    opsel = 2'b01; operand1 = 32'd12345; operand2 = 32'd6789; start = 1'b1;
    tick();
    start = 1'b0;
    dones = 0;
    lat = 0;
    for (int c = 1; c < 80; c++) begin
      if (c == 5 || c == 33) begin
        start = 1'b1; opsel = 2'b10;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        dones++;
        if (lat == 0) begin
          lat = c;
          check("ignore_start_result", {hi, lo}, exp);
        end
      end
      operand1 = $urandom;
      operand2 = $urandom;
      tick();
    end
    start = 1'b0;
    check("ignore_start_done_count", 64'(dones), 64'd1);
    check("ignore_start_latency", 64'(lat), 64'd34);

    // MTLO, MTHI colliding with start, and MTHI/MTLO during RUN.
    old_hi = hi;
    lo_we = 1'b1; wdata = 32'h1234;
    tick();
    lo_we = 1'b0;
    check("mtlo_write", 64'(lo), 64'h1234);
    check("mtlo_hi_kept", 64'(hi), 64'(old_hi));
    hi_we = 1'b1; wdata = 32'hDEAD;
    opsel = 2'b01; operand1 = 32'd2; operand2 = 32'd3; start = 1'b1;
    tick();
    start = 1'b0; hi_we = 1'b0;
    check("start_wins_busy", {63'b0, busy}, 64'd1);
    check("start_wins_hi_kept", 64'(hi), 64'(old_hi));
    cyc = 1;
    while (cyc < 10) begin tick(); cyc++; end
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5555;
    tick(); tick(); tick();
    cyc += 3;
    hi_we = 1'b0; lo_we = 1'b0;
    check("run_we_hi_ignored", 64'(hi), 64'(old_hi));
    check("run_we_lo_ignored", 64'(lo), 64'h1234);
    while (!done && cyc < 80) begin tick(); cyc++; end
    check("mt_op_latency", 64'(cyc), 64'd34);
    check("mt_op_result", {hi, lo}, 64'd6);

    // Reset in cycle 20 of a DIVU aborts it.
    opsel = 2'b11; operand1 = 32'hCAFEF00D; operand2 = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    rst = 1'b1;
    #1;
    check("rst_mid_busy", {63'b0, busy}, 64'd0);
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    check("rst_mid_done", {63'b0, done}, 64'd0);
    tick();
    rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 50; c++) begin
      if (done) dones++;
      tick();
    end
    check("rst_no_done", 64'(dones), 64'd0);
    check("rst_hilo_held", {hi, lo}, 64'd0);
    run_op(2'b11, 32'hCAFEF00D, 32'd7, lat, bcnt);
    check("post_rst_latency", 64'(lat), 64'd34);
    check("post_rst_result", {hi, lo}, model(2'b11, 32'hCAFEF00D, 32'd7));
    tick();

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 60; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        3: ra = 32'($urandom_range(0, 100));
        default: ;
      endcase
      run_op(rop, ra, rb, lat, bcnt);
      check($sformatf("rand%0d_latency", i), 64'(lat), 64'd34);
      check($sformatf("rand%0d_op%0d_%h_%h", i, rop, ra, rb), {hi, lo}, model(rop, ra, rb));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit in the execute stage, next to the ALU. It takes the same two register operands the ALU receives and computes MULT, MULTU, DIV or DIVU over 34 cycles. The 64-bit result is written into the architectural HI/LO registers, which feed the write-back mux for MFHI/MFLO. The control unit stalls the front end while `busy` is high.

## Interface
Parameters:
- `data_width`, 32: operand and HI/LO width. Only 32 is supported.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `operand1`  in  32  rs value: multiplicand or dividend.
- `operand2`  in  32  rt value: multiplier or divisor.
- `opSel`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `start`  in  1  request an operation; sampled only while idle.
- `hi_we`, `lo_we`  in  1  MTHI/MTLO write enables.
- `wdata`  in  32  data for MTHI/MTLO.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse in the cycle new HI/LO are first visible.
- `hi`, `lo`  out  32  architectural HI/LO registers.

## Operation
- States:
  - IDLE: the only state that accepts `start`.
  - RUN: 32 iterations, counter 0..31.
  - FINISH: sign fix-up and HI/LO write.
- IDLE -> RUN when `start`=1. At that edge the unit latches `opSel`, operand magnitudes and result-sign flags; the counter goes to 0.
  - Later changes on the operand inputs have no effect on the running operation.
- RUN performs one iteration per edge and moves to FINISH after the edge with counter=31.
- FINISH -> IDLE unconditionally. On that edge HI/LO are written and `done` is set for one cycle.
- Signed operations work on magnitudes, then apply the sign fix-up:
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
- Multiply uses radix-2 shift-add on a 64-bit accumulator. It ends with hi = product[63:32] and lo = product[31:0].
- Divide uses restoring division on a 33-bit partial remainder. It ends with lo = quotient and hi = remainder.
- Divide by zero (DIV or DIVU) overrides the sign fix-up: lo = 32'hFFFFFFFF, hi = latched operand1 unmodified.
- DIV of 32'h80000000 by 32'hFFFFFFFF gives lo = 32'h80000000, hi = 0. There is no trap.
- `start` while busy (RUN or FINISH) is ignored; it is not queued.
- MTHI/MTLO:
  - `hi_we`/`lo_we` write `wdata` in IDLE only.
  - If `start` and a write enable are both high in the same IDLE cycle, `start` wins and the write is dropped.
  - Write enables in RUN or FINISH are ignored.
- `busy` = (state != IDLE), decoded combinationally from the state register.

## Timing
- Reset (async, takes effect immediately): state IDLE, counter 0, hi = lo = 0, `busy` = 0, `done` = 0. All internal datapath registers are cleared.
- Reset mid-operation aborts the operation; no partial result reaches HI/LO.
- Cycle numbering: `start`=1 is sampled at the end of cycle 0.
  - `busy` = 1 in cycles 1..33 (32 RUN cycles plus 1 FINISH cycle).
  - In cycle 34: `done` = 1, `busy` = 0, and hi/lo hold the new result.
  - Total latency from start to result: 34 cycles.
- A new `start` may be asserted in cycle 34 itself (back-to-back issue). Its `done` comes in cycle 68.
- `done` is low in every cycle except the single completion cycle.
- An MTHI/MTLO write in IDLE is visible on `hi`/`lo` in the following cycle.
- HI/LO keep their values in all cycles except the FINISH edge and accepted MTHI/MTLO edges.

## Test plan
- MULTU 32'hFFFFFFFF × 32'hFFFFFFFF -> in cycle 34 hi = 32'hFFFFFFFE, lo = 32'h00000001; `done` high exactly one cycle; `busy` high cycles 1..33.
- MULT -7 × 3 -> hi = 32'hFFFFFFFF, lo = 32'hFFFFFFEB. Then DIV -7 / 2 issued in cycle 34 -> lo = 32'hFFFFFFFD, hi = 32'hFFFFFFFF, `done` in cycle 68.
- DIVU 100 / 0 -> lo = 32'hFFFFFFFF, hi = 100. DIV 32'h80000000 / 32'hFFFFFFFF -> lo = 32'h80000000, hi = 0.
- While busy, pulse `start` with different operands and toggle operand1/operand2 -> original result unaffected; only one `done` pulse.
- In IDLE: `lo_we` with wdata = 32'h1234 -> lo = 32'h1234 next cycle. Then `hi_we` together with `start` -> write dropped, operation starts. `hi_we` during RUN -> ignored.
- Assert `rst` in cycle 20 of a DIVU -> `busy` = 0 immediately, hi = lo = 0, no `done`. A fresh operation after reset completes normally.
